// File: rtl/signed_sub_with_saturation_pipe.sv
// signed_sub_with_saturation_pipe
//   Streaming signed subtractor: diff = a - b (two's complement), clamped to
//   MAX / MIN on overflow, behind a 2-stage valid/ready pipeline.
//
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     in_valid / in_ready   operand handshake (a, b: W-bit signed)
//     out_valid / out_ready result handshake
//     diff                  saturated a - b
//     sat_pos / sat_neg     result was clamped to MAX / MIN
//
//   Optional build macro SUB_SAT_STATS_EN adds:
//     clr_stats (in)        synchronous clear of sat_cnt, beats an increment
//     sat_cnt   (out)       saturating count of clamped results handed off

// Combinational subtract-and-clamp for one operand pair.
module signed_sub_sat_core #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         sat_pos,
  output logic         sat_neg
);
  logic [W-1:0] raw;

  assign raw = a - b;

  // Overflow is only possible when the operand signs differ; the wrapped
  // result then carries the subtrahend's sign instead of the minuend's.
  assign sat_pos = !a[W-1] &&  b[W-1] &&  raw[W-1];
  assign sat_neg =  a[W-1] && !b[W-1] && !raw[W-1];

  always_comb begin
    diff = raw;
    if (sat_pos)      diff = {1'b0, {(W-1){1'b1}}};
    else if (sat_neg) diff = {1'b1, {(W-1){1'b0}}};
  end
endmodule

module signed_sub_with_saturation_pipe #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     diff,
  output logic             sat_pos,
  output logic             sat_neg
`ifdef SUB_SAT_STATS_EN
  ,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] sat_cnt
`endif
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         sat_pos;
    logic         sat_neg;
  } res_t;

  // vld_pipe[1] = stage-1 valid, vld_pipe[STAGES] = out_valid
  logic [STAGES:1] vld_pipe;
  res_t            s1_nxt, s1_res, s2_res;
  logic            s1_load, s2_load;

  signed_sub_sat_core #(.W(W)) u_core (
    .a       (a),
    .b       (b),
    .diff    (s1_nxt.diff),
    .sat_pos (s1_nxt.sat_pos),
    .sat_neg (s1_nxt.sat_neg)
  );

  // Each stage may load when it is empty or when the stage after it moves
  // on this edge; in_ready therefore sees out_ready combinationally.
  assign s2_load  = !vld_pipe[2] || out_ready;
  assign s1_load  = !vld_pipe[1] || s2_load;
  assign in_ready = s1_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_res   <= '0;
      s2_res   <= '0;
    end else begin
      if (s1_load) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) s1_res <= s1_nxt;
      end
      if (s2_load) begin
        vld_pipe[2] <= vld_pipe[1];
        // data only moves with a valid beat so a bubble leaves diff untouched
        if (vld_pipe[1]) s2_res <= s1_res;
      end
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign diff      = s2_res.diff;
  assign sat_pos   = s2_res.sat_pos;
  assign sat_neg   = s2_res.sat_neg;

`ifdef SUB_SAT_STATS_EN
  logic sat_hs;

  assign sat_hs = out_valid && out_ready && (sat_pos || sat_neg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    sat_cnt <= '0;
    else if (clr_stats)            sat_cnt <= '0;
    else if (sat_hs && !(&sat_cnt)) sat_cnt <= sat_cnt + 1'b1;
  end
`else
  // keeps CNT_W referenced in builds without the counter
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif
endmodule
